output_port_fifo: RTL and testbench
===================================

# output_port_fifo

Parametrised successor to the SAP-1 output register. Captures the W bus into a DEPTH-entry FIFO on each active-low load (`nLo`), instead of overwriting a single register, and drains it to a downstream consumer (display driver, UART, LED latch) over a valid/ready handshake. It sits on the CPU bus in the OUT slot and decouples OUT-instruction timing from a slower consumer.

## Interface
Parameters:
- `WIDTH`, 8: data width of bus and output.
- `DEPTH`, 4: FIFO entries; a power of two, ≥2.

Ports:
- `clk` input 1: single clock; all state updates on posedge.
- `nClr` input 1: synchronous, active-low reset, sampled on posedge `clk`.
- `nLo` input 1: active-low load; bus word is pushed when low at posedge.
- `in` input WIDTH: bus data.
- `out` output WIDTH: head word, or last popped word when empty.
- `out_valid` output 1: FIFO non-empty.
- `out_rdy` input 1: consumer accepts head this cycle.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `count` output $clog2(DEPTH+1): current occupancy.
- `ovf` output 1: sticky overflow flag; present only with `OUTPORT_OVF_FLAG_EN`.

## Operation
- push = !nLo && (!full || pop); pop = out_valid && out_rdy.
- On push, `in` is written at wr_ptr, and wr_ptr advances mod DEPTH.
- On pop, rd_ptr advances mod DEPTH, and the popped word is copied to the hold register.
- count +1 on push only, −1 on pop only, unchanged on both or neither.
- `out` = mem[rd_ptr] while non-empty. It = hold register while empty. This preserves the SAP-1 "display keeps last value" behaviour.
- Pointer widths are $clog2(DEPTH). They wrap naturally. Full/empty come from `count`, not from pointer compare.
- Simultaneous push and pop when full: both happen, the count stays DEPTH, and no overflow occurs.
- Simultaneous push and pop when empty: pop is impossible because out_valid=0. Only the push happens. The new word appears next cycle; no combinational bypass.
- `nLo` low while full without pop: the word is dropped, and FIFO state is unchanged.
- `out_rdy` high while empty: ignored.
- Reset (`nClr` low at posedge) has priority over push/pop in the same cycle:
  - pointers = 0, count = 0, hold register = 0.
  - `out` = 0, `out_valid` = 0, `empty` = 1, `full` = 0, `ovf` = 0.
  - mem contents are not cleared.
- Reset mid-stream discards all queued words.

## Timing
- All outputs are functions of registered state only. There are no combinational paths from `nLo`, `in` or `out_rdy` to any output.
- Push-to-visible latency is 1 cycle. A word loaded at edge N shows on `out` with `out_valid`=1 after edge N.
- Pop takes effect at the edge where `out_valid && out_rdy`. The next word, or the hold value, shows after that edge.
- Throughput is one push and one pop per cycle sustained.
- `full`/`empty`/`count` update on the same edge as the push/pop causing them.

## Configuration
- `OUTPORT_OVF_FLAG_EN` defined:
  - `ovf` port exists.
  - It sets to 1 at the posedge where `!nLo && full && !pop`.
  - It stays set until `nClr` reset.
- Not defined:
  - No `ovf` port or register.
  - Dropped loads are silent.
  - All other behaviour is identical.

## Test plan
- Reset then idle: hold `nClr`=0 one edge → `out`=0x00, `out_valid`=0, `empty`=1, `count`=0.
- Single load: `nLo`=0 with `in`=0x5A for one edge, `out_rdy`=0 → next cycle `out`=0x5A, `out_valid`=1, `count`=1. Then `out_rdy`=1 for one edge → `empty`=1, `out` stays 0x5A.
- Fill and overflow (DEPTH=4):
  - Push 0x01..0x05 with `out_rdy`=0 → `full`=1 after the 4th push, `count`=4, and 0x05 is dropped.
  - `ovf`=1 with the macro; no port without it.
  - Draining yields 0x01,0x02,0x03,0x04.
- Simultaneous full push/pop:
  - Setup: FIFO full with 0x10..0x13.
  - Stimulus: `nLo`=0 with `in`=0x14 and `out_rdy`=1 for one edge.
  - Response: `count` stays 4, `out`=0x11, `ovf` stays 0.
  - A subsequent drain gives 0x11,0x12,0x13,0x14.
- Wrap-around: 10 interleaved push/pop pairs of 0xA0..0xA9 with `out_rdy`=1 → output order matches input order, `count` never exceeds 1, and the pointers wrap past DEPTH correctly.
- Reset mid-operation: `count`=3 and `nClr`=0 with `nLo`=0 on the same edge → `count`=0, `out`=0x00, `out_valid`=0, and the load is discarded.

Source files
------------

// File: rtl/output_port_fifo.sv
// Output port FIFO: buffers OUT-slot bus words and drains them over a valid/ready handshake.
// Optional sticky overflow flag and `ovf` port enabled by defining OUTPORT_OVF_FLAG_EN.
module output_port_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         nClr,
    input  logic                         nLo,
    input  logic [WIDTH-1:0]             in,
    output logic [WIDTH-1:0]             out,
    output logic                         out_valid,
    input  logic                         out_rdy,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef OUTPORT_OVF_FLAG_EN
    ,
    output logic                         ovf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Handshake: a word transfers at a posedge where out_valid && out_rdy are
    // both high; out_valid depends only on registered occupancy, never on out_rdy.

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] hold_q;
    logic             push;
    logic             pop;
    logic             is_full;
    logic             is_empty;

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);

    // A pop frees a slot in the same edge, so a load while full still lands.
    assign pop  = !is_empty && out_rdy;
    assign push = !nLo && (!is_full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in;
        end
    end

    always_ff @(posedge clk) begin
        if (!nClr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                hold_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef OUTPORT_OVF_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (!nClr) begin
            ovf_q <= 1'b0;
        end else if (!nLo && is_full && !pop) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

    // The hold register keeps the last consumed word on display once drained.
    assign out       = is_empty ? hold_q : mem[rd_ptr];
    assign out_valid = !is_empty;
    assign full      = is_full;
    assign empty     = is_empty;
    assign count     = count_q;

endmodule

// File: tb/tb_output_port_fifo.sv
// Bench for output_port_fifo: directed scenarios plus random traffic against a queue model;
// a negedge monitor checks every popped word against the expected queue.
module tb_output_port_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             nClr = 1'b1;
    logic             nLo = 1'b1;
    logic [WIDTH-1:0] in = '0;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_rdy = 1'b0;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
`ifdef OUTPORT_OVF_FLAG_EN
    logic             ovf;
`endif

    output_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .nClr      (nClr),
        .nLo       (nLo),
        .in        (in),
        .out       (out),
        .out_valid (out_valid),
        .out_rdy   (out_rdy),
        .full      (full),
        .empty     (empty),
        .count     (count)
`ifdef OUTPORT_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    // clock
    always #5 clk = ~clk;

    // reference model and scoreboard
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] hold_m = '0;
    bit               ovf_m = 1'b0;
    bit               started = 1'b0;
    int               checks = 0;
    int               errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // monitor: every accepted word must be the oldest expected word
    always @(negedge clk) begin
        if (started && nClr === 1'b1 && out_valid === 1'b1 && out_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected no word at %0t", out, $time);
            end else begin
                chk("pop_data", 32'(out), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_state();
        chk("count", 32'(count), 32'(model_q.size()));
        chk("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
        chk("empty", 32'(empty), 32'(model_q.size() == 0));
        chk("full", 32'(full), 32'(model_q.size() == DEPTH));
        if (model_q.size() == 0) chk("out_hold", 32'(out), 32'(hold_m));
        else                     chk("out_head", 32'(out), 32'(model_q[0]));
`ifdef OUTPORT_OVF_FLAG_EN
        chk("ovf", 32'(ovf), 32'(ovf_m));
`endif
    endtask

    // driver: apply one cycle of inputs, advance the model, check after the edge
    task automatic step(input logic nclr, input logic nlo, input logic [WIDTH-1:0] d, input logic rdy);
        bit mpop;
        bit mpush;
        nClr = nclr;
        nLo = nlo;
        in = d;
        out_rdy = rdy;
        if (!nclr) begin
            model_q.delete();
            exp_q.delete();
            hold_m = '0;
            ovf_m = 1'b0;
        end else begin
            mpop  = (model_q.size() > 0) && rdy;
            mpush = !nlo && ((model_q.size() < DEPTH) || mpop);
            if (!nlo && model_q.size() == DEPTH && !mpop) ovf_m = 1'b1;
            if (mpop) hold_m = model_q.pop_front();
            if (mpush) begin
                model_q.push_back(d);
                exp_q.push_back(d);
            end
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 1'b1, '0, 1'b1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        started = 1'b1;

        // reset then idle
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h00, 1'b0);

        // single load, then consume; out keeps 0x5A
        step(1'b1, 1'b0, 8'h5A, 1'b0);
        step(1'b1, 1'b1, 8'h00, 1'b1);
        chk("hold_5a", 32'(out), 32'h5A);

        // fill and overflow: 0x05 dropped
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        chk("full_after_fill", 32'(full), 32'd1);
        drain();
        chk("hold_after_drain", 32'(out), 32'h04);

        // simultaneous push/pop while full
        step(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
        step(1'b1, 1'b0, 8'h14, 1'b1);
        chk("full_pushpop_out", 32'(out), 32'h11);
        drain();

        // wrap-around with interleaved push/pop pairs
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'(8'hA0 + i), 1'b1);
            step(1'b1, 1'b1, 8'h00, 1'b1);
        end

        // reset mid-operation with a concurrent load
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
        step(1'b0, 1'b0, 8'h77, 1'b0);
        chk("reset_out", 32'(out), 32'h00);
        step(1'b1, 1'b1, 8'h00, 1'b0);

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 1) == 1),
                 8'($urandom_range(0, 255)), ($urandom_range(0, 2) != 0));
        end
        drain();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
